// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_pkg                                                |
// | Description : AES-128 types, S-box and round helper functions.       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [3:0]   rc_t;

    localparam rc_t NUM_ROUNDS = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Byte n of the table sits at bits [2047-8n -: 8].
    localparam logic [2047:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = c_sbox[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] rcon(input rc_t rc);
        case (rc)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic block_t sub_bytes(input block_t s);
        sub_bytes = '0;
        for (int i = 0; i < 16; i++)
            sub_bytes[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    endfunction

    // Bytes are column-major: index = row + 4*col; row r rotates left by r.
    function automatic block_t shift_row(input block_t s);
        shift_row = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                shift_row[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic block_t mix_columns(input block_t s);
        logic [7:0] a0, a1, a2, a3;
        mix_columns = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            mix_columns[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix_columns[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix_columns[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix_columns[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    endfunction

    function automatic block_t key_gen(input rc_t rc, input block_t k);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(rc), 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        key_gen = {w0, w1, w2, w3};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_enc_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_enc_seq_if                                         |
// | Description : Plaintext/key input and ciphertext output handshakes.  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface aes_enc_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    block_t plaintext;
    block_t key;
    logic   out_valid;
    logic   out_ready;
    block_t ciphertext;
    logic   busy;
    rc_t    round_idx;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, round_idx
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, round_idx
    );
endinterface
`default_nettype wire

// File: rtl/aes_round_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_round_step                                         |
// | Description : One combinational AES-128 round plus key expansion.   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module aes_round_step
    import aes_pkg::*;
(
    input  wire block_t i_state,
    input  wire block_t i_round_key,
    input  wire rc_t    i_rc,
    input  wire logic   i_is_last,
    output block_t      o_next_state,
    output block_t      o_next_round_key
);

    block_t w_key;
    block_t w_shifted;
    block_t w_mixed;

    assign w_key            = key_gen(i_rc, i_round_key);
    assign w_shifted        = shift_row(sub_bytes(i_state));
    assign w_mixed          = i_is_last ? w_shifted : mix_columns(w_shifted);
    assign o_next_state     = w_mixed ^ w_key;
    assign o_next_round_key = w_key;

endmodule
`default_nettype wire

// File: rtl/aes_enc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : aes_enc_seq                                            |
// | Description : Iterative AES-128 encryptor, one round per clock.      |
// |               Optional AES_ENC_SEQ_ABORT_EN adds an abort input.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module aes_enc_seq
    import aes_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
`ifdef AES_ENC_SEQ_ABORT_EN
    input  wire logic abort,
`endif
    aes_enc_seq_if.slave bus
);

    state_t r_state;
    rc_t    r_rc;
    block_t r_state_reg;
    block_t r_key_reg;
    logic   r_out_valid;

    block_t w_next_state;
    block_t w_next_key;
    logic   w_is_last;
    logic   w_abort;

`ifdef AES_ENC_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_is_last = (r_rc == NUM_ROUNDS);

    aes_round_step u_round_step (
        .i_state          (r_state_reg),
        .i_round_key      (r_key_reg),
        .i_rc             (r_rc),
        .i_is_last        (w_is_last),
        .o_next_state     (w_next_state),
        .o_next_round_key (w_next_key)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rc        <= '0;
            r_state_reg <= '0;
            r_key_reg   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_state_reg <= bus.plaintext ^ bus.key;
                        r_key_reg   <= bus.key;
                        r_rc        <= 4'd1;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_rc    <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state_reg <= w_next_state;
                        r_key_reg   <= w_next_key;
                        if (w_is_last) begin
                            r_rc        <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_rc <= r_rc + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    // Abort wins over a same-edge output handshake.
                    if (w_abort || bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_rc        <= '0;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = (r_state == ST_IDLE);
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.out_valid  = r_out_valid;
    assign bus.ciphertext = r_state_reg;
    assign bus.round_idx  = (r_state == ST_RUN) ? r_rc : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_aes_enc_seq                                         |
// | Description : Directed known-answer and handshake bench.             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_aes_enc_seq;
    import aes_pkg::*;

    logic clk;
    logic rst;
`ifdef AES_ENC_SEQ_ABORT_EN
    logic abort;
`endif

    aes_enc_seq_if bus();

    aes_enc_seq dut (
        .clk   (clk),
        .rst   (rst),
`ifdef AES_ENC_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    localparam logic [127:0] c_k_c1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_p_c1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_c_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_k_b   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_p_b   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_c_b   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_c_zero = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    vec_t vecs [3];
    int   n_pass;
    int   n_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid; returns edges taken, checking round_idx on the way.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            check("round_idx", 128'(bus.round_idx), 128'(n + 1));
            check("busy_run", 128'(bus.busy), 128'd1);
            tick();
            n++;
        end
    endtask

    task automatic run_vec(input logic [127:0] k, input logic [127:0] pt, input logic [127:0] ct);
        int n;
        bus.key       = k;
        bus.plaintext = pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        check("in_ready_idle", 128'(bus.in_ready), 128'd1);
        tick();
        bus.in_valid = 1'b0;
        wait_done(n);
        check("latency", 128'(n), 128'd10);
        check("ciphertext", bus.ciphertext, ct);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", 128'(bus.out_valid), 128'd0);
    endtask

    initial begin
        int n;
        logic saw_valid;
        n_pass  = 0;
        n_total = 0;
        vecs[0] = '{key: c_k_c1, pt: c_p_c1, ct: c_c_c1};
        vecs[1] = '{key: c_k_b,  pt: c_p_b,  ct: c_c_b};
        vecs[2] = '{key: '0,     pt: '0,     ct: c_c_zero};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
`ifdef AES_ENC_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        #3;
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);
        check("rst_round_idx", 128'(bus.round_idx), 128'd0);
        check("rst_ciphertext", bus.ciphertext, 128'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++)
            run_vec(vecs[i].key, vecs[i].pt, vecs[i].ct);

        // Backpressure with ignored in_valid pulses in RUN and DONE.
        bus.key = c_k_c1; bus.plaintext = c_p_c1; bus.in_valid = 1'b1;
        tick();
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.in_valid  = n[0];
            bus.key       = ~c_k_c1;
            bus.plaintext = 128'hdeadbeef;
            check("in_ready_run", 128'(bus.in_ready), 128'd0);
            tick();
            n++;
        end
        check("bp_latency", 128'(n), 128'd10);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_ciphertext", bus.ciphertext, c_c_c1);
            check("in_ready_done", 128'(bus.in_ready), 128'd0);
            tick();
        end
        // Output handshake and new offer on the same edge: only the handshake completes.
        bus.out_ready = 1'b1;
        tick();
        check("hs_busy", 128'(bus.busy), 128'd0);
        check("hs_in_ready", 128'(bus.in_ready), 128'd1);
        check("hs_out_valid", 128'(bus.out_valid), 128'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();

        // Back-to-back with in_valid and out_ready held high.
        bus.key = c_k_c1; bus.plaintext = c_p_c1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        check("b2b_latency1", 128'(n), 128'd10);
        check("b2b_ct1", bus.ciphertext, c_c_c1);
        bus.key = c_k_b; bus.plaintext = c_p_b;
        tick();
        check("b2b_idle_in_ready", 128'(bus.in_ready), 128'd1);
        check("b2b_idle_busy", 128'(bus.busy), 128'd0);
        tick();
        check("b2b_second_accept", 128'(bus.round_idx), 128'd1);
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        check("b2b_latency2", 128'(n), 128'd10);
        check("b2b_ct2", bus.ciphertext, c_c_b);
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        tick();

        // Asynchronous reset in the middle of round 5.
        bus.key = c_k_b; bus.plaintext = c_p_b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round_idx != 4'd5 && n < 20) begin tick(); n++; end
        check("reach_rc5", 128'(bus.round_idx), 128'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 128'(bus.busy), 128'd0);
        check("arst_in_ready", 128'(bus.in_ready), 128'd1);
        check("arst_round_idx", 128'(bus.round_idx), 128'd0);
        check("arst_ciphertext", bus.ciphertext, 128'd0);
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            saw_valid = saw_valid | bus.out_valid;
        end
        check("arst_no_out_valid", 128'(saw_valid), 128'd0);
        run_vec(c_k_c1, c_p_c1, c_c_c1);

`ifdef AES_ENC_SEQ_ABORT_EN
        bus.key = c_k_b; bus.plaintext = c_p_b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.round_idx != 4'd3 && n < 20) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_ready", 128'(bus.in_ready), 128'd1);
        check("abort_busy", 128'(bus.busy), 128'd0);
        run_vec(c_k_c1, c_p_c1, c_c_c1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
